// File: rtl/vp_key_event_queue_if.sv
// Event handshake between the key event queue (master) and its keymap consumer (slave).
interface vp_key_event_queue_if;
   logic       ev_valid;
   logic [7:0] ev_ascii;
   logic       ev_released;
   logic       ev_ack;

   modport master (output ev_valid, ev_ascii, ev_released, input ev_ack);
   modport slave  (input ev_valid, ev_ascii, ev_released, output ev_ack);
endinterface

// File: rtl/vp_key_event_queue.sv
// Merges joystick keypads into key press/release events and queues them with PS/2 keyboard events.
// Optional feature: define VP_KEY_ANTIGHOST_EN to report at most one merged key pressed at a time.
module vp_key_event_queue #(
   parameter int NUM_JOY      = 2,
   parameter int KEYS_PER_JOY = 10,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                            clk_sys,
   input  logic                            reset,
   input  logic [NUM_JOY*KEYS_PER_JOY-1:0] joy_keys,
   input  logic                            ps2_stb,
   input  logic [7:0]                      ps2_ascii,
   input  logic                            ps2_released,
   vp_key_event_queue_if.master            ev,
   output logic                            overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = (KEYS_PER_JOY > 1) ? $clog2(KEYS_PER_JOY) : 1;

   typedef enum logic {SCAN, STALL} state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d, idx_next;
   logic [KEYS_PER_JOY-1:0] reported_q, reported_d;
   logic [KEYS_PER_JOY-1:0] merged;
   logic [8:0]              mem_q [FIFO_DEPTH];
   logic [8:0]              mem_d [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]             count_q, count_d;
   logic                    overflow_q, overflow_d;

   logic       full, pop, room, push, cur, changed, ghost;
   logic [8:0] push_data;

   function automatic logic [7:0] key_code(input logic [IW-1:0] k);
      int unsigned ki;
      ki = 32'(k);
      if (ki < 9)       key_code = 8'(ki + 32'h31);
      else if (ki == 9) key_code = 8'h30;
      else              key_code = 8'(ki + 32'h80);
   endfunction

   always_comb begin
      merged = '0;
      for (int unsigned j = 0; j < NUM_JOY; j++)
         for (int unsigned k = 0; k < KEYS_PER_JOY; k++)
            merged[k] = merged[k] | joy_keys[j*KEYS_PER_JOY + k];
   end

   always_comb begin
      full     = (count_q == (AW+1)'(FIFO_DEPTH));
      pop      = (count_q != '0) & ev.ev_ack;
      room     = !full || pop;
      cur      = merged[idx_q];
      changed  = cur != reported_q[idx_q];
      idx_next = (idx_q == IW'(KEYS_PER_JOY-1)) ? '0 : idx_q + IW'(1);
`ifdef VP_KEY_ANTIGHOST_EN
      // reported[idx] is 0 whenever a press is pending, so any set bit is another held key
      ghost = cur & (|reported_q);
`else
      ghost = 1'b0;
`endif

      state_d    = state_q;
      idx_d      = idx_q;
      reported_d = reported_q;
      overflow_d = overflow_q;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      push       = 1'b0;
      push_data  = '0;

      if (ps2_stb) begin
         if (room) begin
            push      = 1'b1;
            push_data = {ps2_released, ps2_ascii};
         end else begin
            overflow_d = 1'b1;
         end
      end

      case (state_q)
         SCAN: begin
            if (full && !pop) begin
               state_d = STALL;
            end else if (!changed || ghost) begin
               idx_d = idx_next;
            end else if (!ps2_stb) begin
               push                = 1'b1;
               push_data           = {~cur, key_code(idx_q)};
               reported_d[idx_q]   = cur;
               idx_d               = idx_next;
            end
         end
         STALL: begin
            if (!full) state_d = SCAN;
         end
         default: state_d = SCAN;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= SCAN;
         idx_q      <= '0;
         reported_q <= '0;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         reported_q <= reported_d;
         overflow_q <= overflow_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         mem_q      <= mem_d;
      end
   end

   assign ev.ev_valid    = (count_q != '0);
   assign ev.ev_ascii    = mem_q[rd_ptr_q][7:0];
   assign ev.ev_released = mem_q[rd_ptr_q][8];
   assign overflow       = overflow_q;
endmodule

// File: tb/tb_vp_key_event_queue.sv
// Randomized and directed bench for vp_key_event_queue against a queue-based event model.
module tb_vp_key_event_queue;
   localparam int NJ    = 2;
   localparam int K     = 10;
   localparam int DEPTH = 4;
`ifdef VP_KEY_ANTIGHOST_EN
   localparam bit AG = 1'b1;
`else
   localparam bit AG = 1'b0;
`endif

   logic            clk_sys = 1'b0;
   logic            reset = 1'b1;
   logic [NJ*K-1:0] joy_keys = '0;
   logic            ps2_stb = 1'b0;
   logic [7:0]      ps2_ascii = '0;
   logic            ps2_released = 1'b0;
   logic            overflow;

   vp_key_event_queue_if evif();

   vp_key_event_queue #(.NUM_JOY(NJ), .KEYS_PER_JOY(K), .FIFO_DEPTH(DEPTH)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .joy_keys     (joy_keys),
      .ps2_stb      (ps2_stb),
      .ps2_ascii    (ps2_ascii),
      .ps2_released (ps2_released),
      .ev           (evif),
      .overflow     (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Event model: plain queue of {released, code}, one reported bit per key, scan position.
   logic [8:0]  mq[$];
   logic [K-1:0] mrep;
   int          midx;
   bit          mstall;
   bit          movf;

   function automatic logic mkey(input int k);
      logic r = 1'b0;
      for (int j = 0; j < NJ; j++) r |= joy_keys[j*K + k];
      return r;
   endfunction

   function automatic logic [7:0] kcode(input int k);
      if (k == 9) return 8'h30;
      if (k < 9)  return 8'(8'h31 + k);
      return 8'(8'h80 + k);
   endfunction

   always @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         mq.delete();
         mrep   = '0;
         midx   = 0;
         mstall = 0;
         movf   = 0;
      end else begin : step
         bit full, pop, room, m;
         full = (mq.size() == DEPTH);
         pop  = (mq.size() != 0) && evif.ev_ack;
         room = !full || pop;
         if (pop) void'(mq.pop_front());
         if (ps2_stb) begin
            if (room) mq.push_back({ps2_released, ps2_ascii});
            else      movf = 1;
         end
         if (mstall) begin
            if (!full) mstall = 0;
         end else if (full && !pop) begin
            mstall = 1;
         end else begin
            m = mkey(midx);
            if (m == mrep[midx] || (AG && m && mrep != '0)) begin
               midx = (midx + 1) % K;
            end else if (!ps2_stb) begin
               mq.push_back({!m, kcode(midx)});
               mrep[midx] = m;
               midx = (midx + 1) % K;
            end
         end
      end
   end

   always @(negedge clk_sys) begin
      chk("valid", evif.ev_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("head_ascii", evif.ev_ascii, mq[0][7:0]);
         chk("head_rel", evif.ev_released, mq[0][8]);
      end
      chk("overflow", overflow, movf);
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic wait_valid(input string name, input int bound);
      int c = 0;
      while (!evif.ev_valid && c < bound) begin
         tick();
         c++;
      end
      chk(name, evif.ev_valid, 1);
   endtask

   task automatic take(input string name, input logic [8:0] exp);
      wait_valid(name, 30);
      chk(name, {evif.ev_released, evif.ev_ascii}, exp);
      evif.ev_ack = 1'b1;
      tick();
      evif.ev_ack = 1'b0;
   endtask

   initial begin
      logic [8:0] exp_seq [3];
      int c;
      evif.ev_ack = 1'b0;
      tick(2);
      reset = 1'b0;
      chk("rst_valid", evif.ev_valid, 0);
      chk("rst_ascii", evif.ev_ascii, 8'h00);
      chk("rst_rel", evif.ev_released, 0);
      chk("rst_ovf", overflow, 0);

      // joy0 key 2 -> "3" press within 11 cycles
      joy_keys[2] = 1'b1;
      wait_valid("key3_latency", 11);
      chk("key3_ascii", evif.ev_ascii, 8'h33);
      chk("key3_rel", evif.ev_released, 0);
      evif.ev_ack = 1'b1;
      tick();
      evif.ev_ack = 1'b0;
      chk("key3_popped", evif.ev_valid, 0);
      joy_keys[2] = 1'b0;
      take("key3_release", {1'b1, 8'h33});

      // joy1 key 9 -> "0"; merged OR hides single-joystick release
      joy_keys[19] = 1'b1;
      take("j1k9_press", {1'b0, 8'h30});
      joy_keys[19] = 1'b0;
      take("j1k9_release", {1'b1, 8'h30});
      joy_keys[9] = 1'b1;
      joy_keys[19] = 1'b1;
      take("both_press", {1'b0, 8'h30});
      joy_keys[19] = 1'b0;
      tick(12);
      chk("one_release_no_event", evif.ev_valid, 0);
      joy_keys[9] = 1'b0;
      take("both_release", {1'b1, 8'h30});

      // PS/2 strobe coincides with scanner push of "5"
      c = 0;
      while (midx != 4 && c < 12) begin
         tick();
         c++;
      end
      chk("align_idx4", midx, 4);
      joy_keys[4] = 1'b1;
      ps2_stb = 1'b1;
      ps2_ascii = 8'h61;
      ps2_released = 1'b0;
      tick();
      ps2_stb = 1'b0;
      take("prio_a", {1'b0, 8'h61});
      take("prio_5", {1'b0, 8'h35});
      joy_keys[4] = 1'b0;
      take("key5_release", {1'b1, 8'h35});

      // six transitions into a 4-deep queue
      joy_keys[5:0] = 6'h3F;
      tick(30);
      chk("full_valid", evif.ev_valid, 1);
      chk("full_head", evif.ev_ascii, 8'h31);
      for (int i = 0; i < 6; i++) take("full_press", {1'b0, 8'(8'h31 + i)});
      chk("full_no_ovf", overflow, 0);
      joy_keys[5:0] = 6'h00;
      tick(30);
      ps2_stb = 1'b1;
      ps2_ascii = 8'h7A;
      tick();
      ps2_stb = 1'b0;
      chk("ovf_set", overflow, 1);
      for (int i = 0; i < 6; i++) take("full_release", {1'b1, 8'(8'h31 + i)});
      chk("ovf_sticky", overflow, 1);

      // two overlapping keys
      joy_keys[0] = 1'b1;
      tick(12);
      joy_keys[1] = 1'b1;
      tick(12);
      joy_keys[0] = 1'b0;
      tick(25);
      if (AG) begin
         exp_seq[0] = {1'b0, 8'h31}; exp_seq[1] = {1'b1, 8'h31}; exp_seq[2] = {1'b0, 8'h32};
      end else begin
         exp_seq[0] = {1'b0, 8'h31}; exp_seq[1] = {1'b0, 8'h32}; exp_seq[2] = {1'b1, 8'h31};
      end
      for (int i = 0; i < 3; i++) take("overlap_seq", exp_seq[i]);
      joy_keys[1] = 1'b0;
      take("overlap_rel2", {1'b1, 8'h32});

      // reset with three events queued
      joy_keys[2:0] = 3'b111;
      tick(20);
      chk("pre_rst_valid", evif.ev_valid, 1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_valid", evif.ev_valid, 0);
      chk("midrst_ovf", overflow, 0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) take("held_thru_rst", {1'b0, 8'(8'h31 + i)});
      joy_keys[2:0] = 3'b000;
      for (int i = 0; i < 3; i++) take("held_rel", {1'b1, 8'(8'h31 + i)});

      // randomized traffic with varying consumer rate
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int seg;
         seg = (cyc / 300) % 3;
         if ($urandom_range(0, 7) == 0) begin
            int b;
            b = int'($urandom_range(0, NJ*K-1));
            joy_keys[b] = ~joy_keys[b];
         end
         ps2_stb = ($urandom_range(0, 9) == 0);
         ps2_ascii = 8'($urandom);
         ps2_released = 1'($urandom);
         case (seg)
            0:       evif.ev_ack = 1'($urandom);
            1:       evif.ev_ack = ($urandom_range(0, 7) == 0);
            default: evif.ev_ack = 1'b0;
         endcase
         tick();
      end
      ps2_stb = 1'b0;
      evif.ev_ack = 1'b0;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/vp_key_event_queue.md
VP_KEY_EVENT_QUEUE -- requirements
Module: vp_key_event_queue

Interface
REQ-001 Parameter NUM_JOY, default 2, number of joystick keypads merged (1..4).
REQ-002 Parameter KEYS_PER_JOY, default 10, number of numpad keys per joystick (1..16).
REQ-003 Parameter FIFO_DEPTH, default 8, event queue depth (power of two, 2..16).
REQ-004 The block SHALL have one clock, clk_sys; reset is asynchronous and active-high, port reset.
REQ-005 clk_sys  in  1  system clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 joy_keys  in  NUM_JOY*KEYS_PER_JOY  bit j*KEYS_PER_JOY+k high = joystick j key k held.
REQ-008 ps2_stb  in  1  one-cycle strobe: a decoded keyboard event is present.
REQ-009 ps2_ascii  in  8  keyboard event code.
REQ-010 ps2_released  in  1  keyboard event is a release.
REQ-011 ev_valid  out  1  queue head is valid.
REQ-012 ev_ascii  out  8  queue head code.
REQ-013 ev_released  out  1  queue head is a release.
REQ-014 ev_ack  in  1  consumer read pulse (keymap read acknowledge).
REQ-015 overflow  out  1  sticky: a keyboard event was dropped.

Function
REQ-016 Merged key k SHALL be the OR of key k over all joysticks.
REQ-017 A reported-state vector of KEYS_PER_JOY bits SHALL hold the last state queued per key.
REQ-018 Scanner FSM SHALL have states SCAN and STALL; in SCAN it examines key index idx once per cycle, idx wrapping from KEYS_PER_JOY-1 to 0.
REQ-019 In SCAN, if merged[idx] differs from reported[idx], the scanner SHALL push one event {code(idx), released = ~merged[idx]} and update reported[idx] in the same cycle.
REQ-020 code(k) SHALL be "1".."9" for k=0..8, "0" for k=9, 8'h80+k for k>=10.
REQ-021 A ps2_stb SHALL take priority over a scanner push in the same cycle; the scanner holds idx and retries next cycle.
REQ-022 If the queue is full and no pop occurs that cycle, the scanner SHALL enter STALL without advancing idx or updating reported; it returns to SCAN the cycle after the queue becomes non-full; no joystick transition is ever lost.
REQ-023 A ps2_stb when full with no same-cycle pop SHALL be dropped and set overflow.
REQ-024 Push and pop in the same cycle SHALL both take effect, including when full.
REQ-025 ev_valid SHALL be high exactly when the queue is non-empty; ev_ascii/ev_released SHALL show the head combinationally from storage; a pop occurs on ev_valid & ev_ack; ev_ack while empty is ignored.
REQ-026 Push to ev_valid latency SHALL be one cycle; joystick change to ev_valid SHALL be at most KEYS_PER_JOY+1 cycles with an empty queue.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy uses one extra count bit.

Reset
REQ-028 On reset: queue empty, ev_valid 0, ev_ascii 8'h00, ev_released 0, overflow 0, reported all 0, idx 0, FSM in SCAN.
REQ-029 Keys held through reset release SHALL be reported as presses after reset.
REQ-030 Reset asserted mid-operation SHALL discard all queued events immediately.

Configuration
REQ-031 Macro VP_KEY_ANTIGHOST_EN defined: at most one merged key SHALL be reported pressed at a time; a press seen while another key is reported pressed SHALL be skipped, not queued, and leave reported unchanged, so the key is queued once the held key's release has been queued.
REQ-032 Macro undefined: every key transition SHALL be queued independently.

Verification
REQ-033 Reset, hold joy_keys bit 2 (joy0 key 2) -> within 11 cycles ev_valid=1, ev_ascii="3", ev_released=0; ev_ack -> ev_valid=0.
REQ-034 Joy1 key 9 pressed then released, ack each event -> "0" press, then "0" release; key held on both joysticks, one releases -> no event.
REQ-035 ps2_stb "a" in the same cycle the scanner would push "5" -> queue order "a", "5".
REQ-036 FIFO_DEPTH=4, no acks, 6 joystick transitions -> 4 queued, scanner in STALL; ack all -> remaining 2 delivered, overflow=0; ps2_stb while full -> overflow=1.
REQ-037 VP_KEY_ANTIGHOST_EN: hold "1", then press "2", release "1" -> events "1" press, "1" release, "2" press; undefined -> "1" press, "2" press, "1" release.
REQ-038 Reset asserted with 3 events queued -> ev_valid=0 the same cycle, overflow=0.
